// File: rtl/pq_pkg.sv
// pq_pkg: shared constants and controller state encoding for the Kyber-style
// coefficient-stream datapath (q = 3329, 12-bit coefficients).
package pq_pkg;
  localparam int Q = 3329;
  localparam int DATA_W = 12;
  localparam int N_DEF = 256;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} ctrl_state_t;
endpackage

// File: rtl/mul_watchdog.sv
// mul_watchdog: counts cycles elapsed since the last clear and flags expiry
// once TIMEOUT of them pass without another clear.
module mul_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  // A clear loads 1 so the count reads as cycles elapsed including the next one.
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= CW'(1);
    else if (i_en && r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + CW'(1);
  end
  assign o_expired = i_en && !i_clr && r_cnt >= CW'(TIMEOUT - 1);
endmodule

// File: rtl/poly_pointwise_mul_ctrl.sv
// poly_pointwise_mul_ctrl: streams operand pairs from two coefficient RAMs into a
// modular multiplier and writes results, in arrival order, into a result RAM.
module poly_pointwise_mul_ctrl #(
  parameter int DATA_W = pq_pkg::DATA_W,
  parameter int N = pq_pkg::N_DEF,
  parameter int ADDR_W = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_a_rd_data,
  input  logic [DATA_W-1:0] i_b_rd_data,
  output logic              o_mul_en,
  output logic [DATA_W-1:0] o_mul_a,
  output logic [DATA_W-1:0] o_mul_b,
  input  logic [DATA_W-1:0] i_mul_result,
  input  logic              i_mul_valid,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data
);
  import pq_pkg::*;
  localparam int CW = ADDR_W + 1;
  if (2 ** ADDR_W < N) begin : g_bad_addr_w
    $error("ADDR_W too narrow for N");
  end
  ctrl_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_rd_cnt, r_wr_cnt;
  logic r_rd_en, r_mul_en, r_wr_en, r_err;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_a_hold, r_b_hold, r_wr_data;
  logic w_go, w_accept, w_last_rd, w_rd_step, w_all_written, w_expired;
  assign w_go = r_state == IDLE && i_start;
  assign w_accept = i_mul_valid && (r_state == ISSUE || r_state == DRAIN);
  assign w_last_rd = r_state == ISSUE && r_rd_cnt == CW'(N - 1);
  assign w_rd_step = r_state == ISSUE && !w_last_rd;
  // Counting the result being accepted this cycle lets DONE follow the last write directly.
  assign w_all_written = r_wr_cnt + CW'(w_accept) == CW'(N);
  mul_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_accept || r_state != DRAIN),
    .i_en      (r_state == DRAIN),
    .o_expired (w_expired)
  );
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = i_start ? ISSUE : IDLE;
      ISSUE:   w_state_nxt = w_last_rd ? DRAIN : ISSUE;
      DRAIN:   w_state_nxt = (w_all_written || w_expired) ? DONE : DRAIN;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rd_en   <= 1'b0;
      r_rd_cnt  <= '0;
      r_mul_en  <= 1'b0;
      r_a_hold  <= '0;
      r_b_hold  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_cnt  <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_en  <= w_go || w_rd_step;
      r_rd_cnt <= w_go ? '0 : w_rd_step ? r_rd_cnt + CW'(1) : r_rd_cnt;
      r_mul_en <= r_rd_en;
      if (r_mul_en) begin
        r_a_hold <= i_a_rd_data;
        r_b_hold <= i_b_rd_data;
      end
      r_wr_en  <= w_accept;
      if (w_accept) begin
        r_wr_addr <= r_wr_cnt[ADDR_W-1:0];
        r_wr_data <= i_mul_result;
      end
      r_wr_cnt <= w_go ? '0 : r_wr_cnt + CW'(w_accept);
      r_err    <= w_go ? 1'b0 : (r_state == DRAIN && w_expired && !w_all_written) ? 1'b1 : r_err;
    end
  end
  assign o_busy    = r_state == ISSUE || r_state == DRAIN;
  assign o_done    = r_state == DONE;
  assign o_err     = r_err;
  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_rd_cnt[ADDR_W-1:0];
  assign o_mul_en  = r_mul_en;
  // Operands pass straight through while valid and otherwise hold the last pair.
  assign o_mul_a   = r_mul_en ? i_a_rd_data : r_a_hold;
  assign o_mul_b   = r_mul_en ? i_b_rd_data : r_b_hold;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
endmodule

// File: tb/tb_poly_pointwise_mul_ctrl.sv
// tb_poly_pointwise_mul_ctrl: scoreboard bench with RAM and multiplier models;
// one N=4 instance and one N=256 instance share the models via a select.
module tb_poly_pointwise_mul_ctrl;
  import pq_pkg::*;
  localparam int AW = 8;
  localparam int TO = 64;
  logic clk = 0, rst = 1, start = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  bit sel = 0;
  int lat = 3, n_cur = 4, issued = 0;
  bit drop = 0;
  int tests = 0, fails = 0;
  logic [DATA_W-1:0] mem_a [256];
  logic [DATA_W-1:0] mem_b [256];
  logic [DATA_W-1:0] a_rd = '0, b_rd = '0, mul_result;
  logic mul_valid;
  logic busy4, done4, err4, rd_en4, mul_en4, wr_en4;
  logic [AW-1:0] rd_addr4, wr_addr4;
  logic [DATA_W-1:0] mul_a4, mul_b4, wr_data4;
  logic busy9, done9, err9, rd_en9, mul_en9, wr_en9;
  logic [AW-1:0] rd_addr9, wr_addr9;
  logic [DATA_W-1:0] mul_a9, mul_b9, wr_data9;
  poly_pointwise_mul_ctrl #(.N(4), .ADDR_W(AW), .TIMEOUT(TO)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(start && !sel), .o_busy(busy4), .o_done(done4), .o_err(err4),
    .o_rd_en(rd_en4), .o_rd_addr(rd_addr4), .i_a_rd_data(a_rd), .i_b_rd_data(b_rd),
    .o_mul_en(mul_en4), .o_mul_a(mul_a4), .o_mul_b(mul_b4), .i_mul_result(mul_result),
    .i_mul_valid(mul_valid && !sel), .o_wr_en(wr_en4), .o_wr_addr(wr_addr4), .o_wr_data(wr_data4));
  poly_pointwise_mul_ctrl #(.N(256), .ADDR_W(AW), .TIMEOUT(TO)) u_dut256 (
    .clk(clk), .rst(rst), .i_start(start && sel), .o_busy(busy9), .o_done(done9), .o_err(err9),
    .o_rd_en(rd_en9), .o_rd_addr(rd_addr9), .i_a_rd_data(a_rd), .i_b_rd_data(b_rd),
    .o_mul_en(mul_en9), .o_mul_a(mul_a9), .o_mul_b(mul_b9), .i_mul_result(mul_result),
    .i_mul_valid(mul_valid && sel), .o_wr_en(wr_en9), .o_wr_addr(wr_addr9), .o_wr_data(wr_data9));
  logic busy, done, err, rd_en, mul_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] mul_a, mul_b, wr_data;
  assign busy = sel ? busy9 : busy4;
  assign done = sel ? done9 : done4;
  assign err = sel ? err9 : err4;
  assign rd_en = sel ? rd_en9 : rd_en4;
  assign rd_addr = sel ? rd_addr9 : rd_addr4;
  assign mul_en = sel ? mul_en9 : mul_en4;
  assign mul_a = sel ? mul_a9 : mul_a4;
  assign mul_b = sel ? mul_b9 : mul_b4;
  assign wr_en = sel ? wr_en9 : wr_en4;
  assign wr_addr = sel ? wr_addr9 : wr_addr4;
  assign wr_data = sel ? wr_data9 : wr_data4;
  always @(posedge clk) if (rd_en) begin
    a_rd <= mem_a[rd_addr];
    b_rd <= mem_b[rd_addr];
  end
  logic [DATA_W:0] pipe [1:8] = '{default: '0};
  logic s0_v;
  logic [DATA_W-1:0] s0_d;
  assign s0_v = mul_en && !(drop && issued == n_cur - 1);
  assign s0_d = DATA_W'((32'(mul_a) * 32'(mul_b)) % Q);
  always @(posedge clk) begin
    issued <= start ? 0 : issued + (mul_en ? 1 : 0);
    pipe[1] <= {s0_v, s0_d};
    for (int i = 2; i <= 8; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_valid = (lat == 0) ? s0_v : pipe[lat][DATA_W];
  assign mul_result = (lat == 0) ? s0_d : pipe[lat][DATA_W-1:0];
  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  function automatic void check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction
  int done_cnt = 0, stray = 0, busy_first = -1, busy_last = -1;
  logic busy_prev = 0;
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (busy && !busy_prev) busy_first = cyc;
    if (busy) busy_last = cyc;
    busy_prev = busy;
    if (wr_en && !busy && !done) stray++;
    if (wr_en && !rst) begin
      if (exp_q.size() == 0) check("unexpected_wr", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(wr_addr), e.addr);
        check("wr_data", int'(wr_data), e.data);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic kick(output int k);
    start = 1;
    k = cyc;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input int lim, output int dc);
    dc = -1;
    for (int i = 0; i < lim; i++) begin
      if (done) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (dc < 0) check("done_timeout", 0, 1);
  endtask
  task automatic load(input int n, input bit rnd, input int skip_last);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        mem_a[i] = DATA_W'($urandom_range(0, Q - 1));
        mem_b[i] = DATA_W'($urandom_range(0, Q - 1));
      end
      if (i < n - skip_last) exp_q.push_back('{i, (int'(mem_a[i]) * int'(mem_b[i])) % Q});
    end
  endtask
  task automatic check_idle(input string name);
    check({name, "_ctl"}, int'({busy, done, err, rd_en, mul_en, wr_en}), 0);
    check({name, "_addr"}, int'({rd_addr, wr_addr}), 0);
    check({name, "_data"}, int'({mul_a, mul_b, wr_data}), 0);
  endtask
  initial begin
    int k, k2, dc, d0, s0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    tick(3);
    rst = 0;
    tick(1);
    check_idle("reset");
    // Scenario 1: N=4, L=3, fixed operands
    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
    mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
    check("s1_model_q", (int'(mem_a[3]) * int'(mem_b[3])) % Q, 32);
    load(4, 0, 0);
    d0 = done_cnt;
    kick(k);
    wait_done(100, dc);
    check("s1_done_cyc", dc, k + 9);
    check("s1_err", int'(err), 0);
    tick(1);
    check("s1_busy_first", busy_first, k + 1);
    check("s1_busy_last", busy_last, k + 8);
    tick(10);
    check("s1_done_cnt", done_cnt - d0, 1);
    check("s1_pending", exp_q.size(), 0);
    // Scenario 3: second start while busy is ignored
    load(4, 0, 0);
    d0 = done_cnt;
    kick(k);
    tick(2);
    start = 1;
    tick(1);
    start = 0;
    wait_done(100, dc);
    check("s3_done_cyc", dc, k + 9);
    tick(15);
    check("s3_done_cnt", done_cnt - d0, 1);
    check("s3_pending", exp_q.size(), 0);
    // Scenario 2: N=256, L=7, random operands
    sel = 1; lat = 7; n_cur = 256;
    tick(2);
    load(256, 1, 0);
    d0 = done_cnt;
    s0 = stray;
    kick(k);
    wait_done(600, dc);
    check("s2_done_cyc", dc, k + 256 + 7 + 2);
    check("s2_err", int'(err), 0);
    tick(20);
    check("s2_done_cnt", done_cnt - d0, 1);
    check("s2_pending", exp_q.size(), 0);
    check("s2_wr_after_done", stray - s0, 0);
    // Scenario 4: last valid dropped, watchdog aborts
    sel = 0; lat = 3; n_cur = 4; drop = 1;
    tick(2);
    load(4, 1, 1);
    kick(k);
    wait_done(200, dc);
    check("s4_done_cyc", dc, k + 7 + TO);
    check("s4_err", int'(err), 1);
    check("s4_pending", exp_q.size(), 0);
    tick(1);
    check("s4_err_sticky", int'(err), 1);
    tick(15);
    drop = 0;
    // Scenario 5: reset mid-run at k+5
    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
    mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
    d0 = done_cnt;
    s0 = stray;
    kick(k);
    check("s5_err_cleared", int'(err), 0);
    check("s5_busy", int'(busy), 1);
    tick(4);
    rst = 1;
    tick(1);
    rst = 0;
    check_idle("s5_rst");
    tick(20);
    check("s5_done_cnt", done_cnt - d0, 0);
    check("s5_wr", stray - s0, 0);
    // Scenario 6: L=0 and a back-to-back start right after done
    lat = 0;
    load(4, 1, 0);
    load(4, 0, 0);
    d0 = done_cnt;
    kick(k);
    wait_done(100, dc);
    check("s6_done_cyc1", dc, k + 6);
    tick(1);
    kick(k2);
    check("s6_busy2", int'(busy), 1);
    check("s6_start_gap", k2, dc + 1);
    wait_done(100, dc);
    check("s6_done_cyc2", dc, k2 + 6);
    tick(10);
    check("s6_done_cnt", done_cnt - d0, 2);
    check("s6_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/poly_pointwise_mul_ctrl.md
Name: poly_pointwise_mul_ctrl

Overview:
Upstream and downstream controller around montgomery_multiply. Performs a pointwise product of two N-coefficient 12-bit polynomials mod q=3329.
- Streams operand pairs out of two coefficient RAMs into the multiplier, one pair per cycle, on mul_en/mul_a/mul_b.
- Collects mul_valid/mul_result and writes each result into a result RAM in order.
- Signals done when all N results have landed.
- Latency-agnostic: completion is found by counting mul_valid pulses, not by assuming a fixed pipeline depth.

Parameters:
DATA_W, 12, coefficient width (q=3329 fits).
N, 256, coefficients per polynomial.
ADDR_W, 8, RAM address width; must satisfy 2**ADDR_W >= N.
TIMEOUT, 64, maximum cycles in DRAIN without a mul_valid before aborting.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a run; ignored unless IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the run ends (normal or timeout)
err  out  1  sticky timeout flag; cleared by the next accepted start or by rst
rd_en  out  1  read strobe to both operand RAMs
rd_addr  out  ADDR_W  shared read address for the A and B RAMs
a_rd_data  in  DATA_W  A RAM data, valid 1 cycle after rd_en
b_rd_data  in  DATA_W  B RAM data, valid 1 cycle after rd_en
mul_en  out  1  operand-valid to the multiplier
mul_a  out  DATA_W  operand a
mul_b  out  DATA_W  operand b
mul_result  in  DATA_W  multiplier result
mul_valid  in  1  multiplier result valid
wr_en  out  1  result RAM write strobe
wr_addr  out  ADDR_W  result address
wr_data  out  DATA_W  result data

Behaviour:
- Reset values: busy=0, done=0, err=0, rd_en=0, rd_addr=0, mul_en=0, mul_a=0, mul_b=0, wr_en=0, wr_addr=0, wr_data=0. FSM goes to IDLE. Both counters clear.
- rst mid-run aborts immediately. No done pulse. Late mul_valid pulses are ignored because mul_valid is only honoured in ISSUE and DRAIN.
- FSM IDLE -> ISSUE:
  - Condition: start=1 while in IDLE (edge k).
  - Effects: err cleared, busy=1 from k+1, rd_cnt=0, wr_cnt=0.
- ISSUE:
  - rd_en=1 with rd_addr = 0..N-1 on consecutive cycles k+1..k+N.
  - After issuing address N-1, go to DRAIN.
- Operand path:
  - Registered: mul_en = rd_en delayed 1 cycle, so mul_en is high on cycles k+2..k+N+1.
  - mul_a/mul_b are driven directly from a_rd_data/b_rd_data. No additional register stage.
  - mul_a/mul_b hold their last value when mul_en=0.
- Result path, accepted in ISSUE or DRAIN:
  - On each mul_valid: registered wr_en=1, wr_addr=wr_cnt, wr_data=mul_result, then wr_cnt++.
  - Results are written strictly in arrival order. The multiplier is in-order.
- DRAIN:
  - Watchdog counts cycles since the last mul_valid. It is reset on every mul_valid and on entry to DRAIN.
  - When wr_cnt reaches N, the cycle after the last write goes to DONE.
  - If the watchdog hits TIMEOUT first: err=1, go to DONE.
- Simultaneous events:
  - mul_valid can arrive during ISSUE; it is accepted there.
  - If the N-th mul_valid and the watchdog expiry coincide, the valid wins: no err.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Counters are ADDR_W+1 bits wide, so N=2**ADDR_W does not wrap before the compare.
- mul_valid beyond N in one run cannot be written: the FSM leaves DRAIN on the count, so extras are dropped.
- start while busy is ignored, with no restart and no error.

Decomposition:
- Shared package pq_pkg holds:
  - Q=3329 and DATA_W=12.
  - The ctrl_state_t enum {IDLE, ISSUE, DRAIN, DONE}.
  - Default N.
- One natural sub-module, mul_watchdog: the cycle counter with clear, enable and expiry; reusable by other coefficient-stream controllers.
- Address and counter logic stays inline.

Test Plan:
1. Run with a model multiplier returning a*b mod 3329 at latency L=3.
   - Stimulus: N=4, A={1,2,3,4}, B={5,6,7,8}, start at edge k.
   - Required: result RAM = {5,12,21,32}, wr_addr 0..3 in order, done pulse at k+9, busy high k+1..k+8, err=0.
2. Full size N=256 with random operands and L=7.
   - Required: all 256 writes match the reference model, exactly one done pulse, no wr_en after done.
3. Pulse start again at k+3 while busy.
   - Required: ignored; run completes identically to scenario 1, with a single done pulse.
4. Model multiplier drops the last valid, with TIMEOUT=64.
   - Required: 3 writes, then err=1 and a done pulse 64 cycles after the 3rd valid; err clears on the next start.
5. Assert rst for one cycle at k+5 of scenario 1.
   - Required: all outputs return to reset values next cycle; the model's trailing valids produce no wr_en; no done pulse.
6. Latency L=0 (mul_valid concurrent with mul_en), then a back-to-back start in the cycle after done.
   - Required: both runs correct; the second start is accepted because the FSM is in IDLE.
